// File: rtl/axi4lite_timer_pkg.sv
// Shared register map, control-field layout and byte-lane merge helper for axi4lite_timer.
package axi4lite_timer_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_CMP    = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_PSC    = 3'd4;

    typedef struct packed {
        logic autoclr;
        logic ie;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for axi4lite_timer: counts 0..psc while enabled and strobes tick_o on the terminal count.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] psc,
    input  logic        psc_wr,
    output logic        tick_o
);

    logic [15:0] cnt;

    assign tick_o = en && (cnt == psc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (psc_wr)
            cnt <= '0;
        else if (en)
            cnt <= tick_o ? 16'd0 : cnt + 16'd1;
    end

endmodule

// File: rtl/axi4lite_timer.sv
// AXI4-Lite timer: up-counter with compare, sticky match flag and level interrupt.
// Optional prescaler register/strobe enabled by defining TIMER_PRESCALER_EN.
module axi4lite_timer
    import axi4lite_timer_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] timer_axi_awaddr,
    input  logic              timer_axi_awvalid,
    output logic              timer_axi_awready,
    input  logic [DATA_W-1:0] timer_axi_wdata,
    input  logic [3:0]        timer_axi_wstrb,
    input  logic              timer_axi_wvalid,
    output logic              timer_axi_wready,
    input  logic [ADDR_W-1:0] timer_axi_araddr,
    input  logic              timer_axi_arvalid,
    output logic              timer_axi_arready,
    output logic [DATA_W-1:0] timer_axi_rdata,
    output logic              timer_axi_rvalid,
    input  logic              timer_axi_rready,
    output logic              irq_o
);

    logic              wr_en;
    logic              rd_en;
    logic [2:0]        wr_idx;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] cmp;
    logic              match_flag;
    logic              tick;
    logic              step;
    logic              hit;
    logic [DATA_W-1:0] rd_val;
    logic              unused_addr_bits;

    // Write needs AW and W together; nothing is accepted while reset is asserted.
    assign wr_en             = ~rst & timer_axi_awvalid & timer_axi_wvalid;
    assign timer_axi_awready = wr_en;
    assign timer_axi_wready  = wr_en;
    assign timer_axi_arready = ~rst & ~timer_axi_rvalid;
    assign rd_en             = timer_axi_arvalid & timer_axi_arready;
    assign wr_idx            = timer_axi_awaddr[4:2];

    assign unused_addr_bits = ^{timer_axi_awaddr[ADDR_W-1:5], timer_axi_awaddr[1:0],
                                timer_axi_araddr[ADDR_W-1:5], timer_axi_araddr[1:0]};

`ifdef TIMER_PRESCALER_EN
    logic [15:0] psc;
    logic        psc_wr;

    assign psc_wr = wr_en && (wr_idx == REG_PSC);

    timer_prescaler u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl.en),
        .psc    (psc),
        .psc_wr (psc_wr),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
        end else if (psc_wr) begin
            if (timer_axi_wstrb[0]) psc[7:0]  <= timer_axi_wdata[7:0];
            if (timer_axi_wstrb[1]) psc[15:8] <= timer_axi_wdata[15:8];
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step = ctrl.en & tick;
    assign hit  = step && (count == cmp);

    // Software writes to COUNT win over increment/auto-clear; a match wins over W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl       <= '0;
            count      <= '0;
            cmp        <= CMP_RST;
            match_flag <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (wr_en && (wr_idx == REG_CTRL) && timer_axi_wstrb[0])
                ctrl <= ctrl_t'(timer_axi_wdata[2:0]);

            if (wr_en && (wr_idx == REG_COUNT))
                count <= apply_wstrb(count, timer_axi_wdata, timer_axi_wstrb);
            else if (hit && ctrl.autoclr)
                count <= '0;
            else if (step)
                count <= count + 1'b1;

            if (wr_en && (wr_idx == REG_CMP))
                cmp <= apply_wstrb(cmp, timer_axi_wdata, timer_axi_wstrb);

            if (hit)
                match_flag <= 1'b1;
            else if (wr_en && (wr_idx == REG_STATUS) && timer_axi_wstrb[0] && timer_axi_wdata[0])
                match_flag <= 1'b0;

            irq_o <= match_flag & ctrl.ie;
        end
    end

    always_comb begin
        rd_val = '0;
        case (timer_axi_araddr[4:2])
            REG_CTRL:   rd_val = {29'b0, ctrl};
            REG_COUNT:  rd_val = count;
            REG_CMP:    rd_val = cmp;
            REG_STATUS: rd_val = {31'b0, match_flag};
`ifdef TIMER_PRESCALER_EN
            REG_PSC:    rd_val = {16'b0, psc};
`endif
            default:    rd_val = '0;
        endcase
    end

    // Single outstanding read; data captured at the AR handshake and held until rready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_axi_rvalid <= 1'b0;
            timer_axi_rdata  <= '0;
        end else if (rd_en) begin
            timer_axi_rvalid <= 1'b1;
            timer_axi_rdata  <= rd_val;
        end else if (timer_axi_rready) begin
            timer_axi_rvalid <= 1'b0;
        end
    end

endmodule
